// File: rtl/hazard3_apb_bridge_if.sv
// ---------------------------------------------------------------------------
// hazard3_apb_bridge_if
// Bus bundle for the AHB5 -> APB3 bridge. Carries both the AHB5 subordinate
// signals and the APB3 requester signals so the bridge has a single bus port.
//
// Parameters:
//   W_ADDR   AHB address width
//   W_PADDR  APB address width
//   W_DATA   AHB/APB data width
//
// Signals (direction as seen by the bridge, modport slave):
//   AHB in : hsel, haddr, hwrite, htrans, hsize, hready, hwdata
//   AHB out: hready_resp, hresp, hrdata
//   APB out: psel, penable, pwrite, paddr, pwdata
//   APB in : prdata, pready, pslverr
// Modport master is the opposite view (AHB manager + APB completer).
// ---------------------------------------------------------------------------
interface hazard3_apb_bridge_if #(
    parameter int unsigned W_ADDR  = 32,
    parameter int unsigned W_PADDR = 16,
    parameter int unsigned W_DATA  = 32
);
    // AHB5 side
    logic              hsel;
    logic [W_ADDR-1:0] haddr;
    logic              hwrite;
    logic [1:0]        htrans;
    logic [2:0]        hsize;
    logic              hready;
    logic [W_DATA-1:0] hwdata;
    logic              hready_resp;
    logic              hresp;
    logic [W_DATA-1:0] hrdata;

    // APB3 side
    logic               psel;
    logic               penable;
    logic               pwrite;
    logic [W_PADDR-1:0] paddr;
    logic [W_DATA-1:0]  pwdata;
    logic [W_DATA-1:0]  prdata;
    logic               pready;
    logic               pslverr;

    modport slave (
        input  hsel, haddr, hwrite, htrans, hsize, hready, hwdata,
        output hready_resp, hresp, hrdata,
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport master (
        output hsel, haddr, hwrite, htrans, hsize, hready, hwdata,
        input  hready_resp, hresp, hrdata,
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/hazard3_apb_bridge.sv
// ---------------------------------------------------------------------------
// hazard3_apb_bridge
// AHB5 subordinate to APB3 requester bridge. One AHB transfer maps onto one
// APB transfer; only word-sized writes are bridged, narrower/wider writes get
// a two-cycle AHB error response without touching APB. Reads of any size are
// forwarded as full-width APB reads.
//
// Ports:
//   clk   single clock, all state updates on posedge
//   rst   asynchronous, active-high reset
//   bus   hazard3_apb_bridge_if.slave (AHB5 subordinate + APB3 requester)
//
// Parameters: W_ADDR, W_PADDR, W_DATA (must match the bus instance).
//
// Build option: define HAZARD3_APB_BRIDGE_TIMEOUT_EN to add an 8-bit APB
// wait-state watchdog; after 255 consecutive ACCESS cycles without pready
// the transfer is abandoned with an AHB error response. Without the macro
// the bridge waits for pready indefinitely.
// ---------------------------------------------------------------------------
module hazard3_apb_bridge #(
    parameter int unsigned W_ADDR  = 32,
    parameter int unsigned W_PADDR = 16,
    parameter int unsigned W_DATA  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    hazard3_apb_bridge_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE,
        WDATA,
        SETUP,
        ACCESS,
        ERR1,
        ERR2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic               accept;
    logic               size_bad;
    logic               tmo_hit;

    logic               psel_c;
    logic               penable_c;
    logic               hready_resp_c;
    logic               hresp_c;

    logic [W_PADDR-1:0] paddr_q;
    logic               pwrite_q;
    logic [W_DATA-1:0]  pwdata_q;
    logic [W_DATA-1:0]  hrdata_q;

    // Upper AHB address bits and htrans[0] (SEQ vs NONSEQ) carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{bus.haddr[W_ADDR-1:W_PADDR], bus.htrans[0]};

    // A new address phase can only land while the previous data phase is
    // finishing (IDLE or the second error cycle).
    assign accept   = bus.hsel & bus.htrans[1] & bus.hready
                    & ((state == IDLE) | (state == ERR2));
    assign size_bad = bus.hwrite & (bus.hsize != 3'b010);

`ifdef HAZARD3_APB_BRIDGE_TIMEOUT_EN
    logic [7:0] tmo_cnt;

    // The 255th stalled ACCESS cycle is the one that sees the count at 254.
    assign tmo_hit = (tmo_cnt == 8'd254);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state_nxt == SETUP) begin
            tmo_cnt <= '0;
        end else if ((state == ACCESS) && !bus.pready) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        psel_c        = 1'b0;
        penable_c     = 1'b0;
        hready_resp_c = 1'b1;
        hresp_c       = 1'b0;

        case (state)
            IDLE, ERR2: begin
                hresp_c = (state == ERR2);
                if (accept) begin
                    if (size_bad) begin
                        state_nxt = ERR1;
                    end else if (bus.hwrite) begin
                        state_nxt = WDATA;
                    end else begin
                        state_nxt = SETUP;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            WDATA: begin
                hready_resp_c = 1'b0;
                state_nxt     = SETUP;
            end
            SETUP: begin
                psel_c        = 1'b1;
                hready_resp_c = 1'b0;
                state_nxt     = ACCESS;
            end
            ACCESS: begin
                psel_c        = 1'b1;
                penable_c     = 1'b1;
                hready_resp_c = 1'b0;
                if (bus.pready) begin
                    state_nxt = bus.pslverr ? ERR1 : IDLE;
                end else if (tmo_hit) begin
                    state_nxt = ERR1;
                end
            end
            ERR1: begin
                hready_resp_c = 1'b0;
                hresp_c       = 1'b1;
                state_nxt     = ERR2;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            hrdata_q <= '0;
        end else begin
            if (accept) begin
                paddr_q  <= bus.haddr[W_PADDR-1:0];
                pwrite_q <= bus.hwrite;
            end
            // AHB write data is valid in the cycle after the address phase.
            if (state == WDATA) begin
                pwdata_q <= bus.hwdata;
            end
            if ((state == ACCESS) && bus.pready && !bus.pslverr && !pwrite_q) begin
                hrdata_q <= bus.prdata;
            end
        end
    end

    assign bus.psel        = psel_c;
    assign bus.penable     = penable_c;
    assign bus.hready_resp = hready_resp_c;
    assign bus.hresp       = hresp_c;
    assign bus.paddr       = paddr_q;
    assign bus.pwrite      = pwrite_q;
    assign bus.pwdata      = pwdata_q;
    assign bus.hrdata      = hrdata_q;

endmodule

// File: tb/tb_hazard3_apb_bridge.sv
// ---------------------------------------------------------------------------
// tb_hazard3_apb_bridge
// Directed plus randomized transfers against hazard3_apb_bridge. Expected
// outcomes (latency, error, APB select/enable counts, read data) come from a
// transfer-level model of the bridge's contract. Honors
// HAZARD3_APB_BRIDGE_TIMEOUT_EN for the stalled-completer case.
// ---------------------------------------------------------------------------
module tb_hazard3_apb_bridge;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    hazard3_apb_bridge_if #(.W_ADDR(32), .W_PADDR(16), .W_DATA(32)) bus ();

    hazard3_apb_bridge #(.W_ADDR(32), .W_PADDR(16), .W_DATA(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned passed = 0;
    int unsigned total  = 0;
    logic [31:0] exp_hrdata = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One AHB transfer, started at a negedge where the bridge is ready.
    // Returns at the negedge of the cycle in which hready_resp goes high.
    task automatic xfer(input bit wr, input logic [2:0] sz, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input int waits, input bit err);
        bit bad, tmo, eerr, stab_bad, done, last_hresp, last_hrdy;
        int lat, base, epsel, epen, c, pcount, ecount;
        bad  = wr && (sz != 3'd2);
        base = wr ? 4 : 3;
`ifdef HAZARD3_APB_BRIDGE_TIMEOUT_EN
        tmo = !bad && (waits >= 255);
`else
        tmo = 1'b0;
`endif
        eerr  = bad || err || tmo;
        lat   = bad ? 2 : (tmo ? base + 255 : base + waits + (err ? 1 : 0));
        epsel = bad ? 0 : (tmo ? 256 : 2 + waits);
        epen  = bad ? 0 : (tmo ? 255 : 1 + waits);
        if (!wr && !eerr) exp_hrdata = rdata;

        chk("ready_before_addr", {63'd0, bus.hready_resp}, 64'd1);
        bus.hsel   = 1'b1;
        bus.htrans = 2'b10;
        bus.haddr  = addr;
        bus.hwrite = wr;
        bus.hsize  = sz;
        bus.hready = 1'b1;

        c = 0; pcount = 0; ecount = 0; stab_bad = 0; done = 0;
        last_hresp = 0; last_hrdy = 1;
        while (!done && c < 600) begin
            @(posedge clk);
            @(negedge clk);
            c++;
            if (c == 1) begin
                bus.htrans = 2'b00;
                bus.hsel   = 1'($urandom);
                bus.haddr  = $urandom;
                bus.hwrite = 1'($urandom);
                bus.hwdata = wdata;
            end
            if (bus.psel) begin
                pcount++;
                if (bus.paddr !== addr[15:0] || bus.pwrite !== wr) stab_bad = 1;
                if (wr && bus.pwdata !== wdata) stab_bad = 1;
            end
            if (bus.penable) begin
                if (!bus.psel) stab_bad = 1;
                ecount++;
                bus.pready  = (ecount > waits);
                bus.pslverr = err && (ecount > waits);
                bus.prdata  = (ecount > waits) ? rdata : $urandom;
            end else begin
                bus.pready  = 1'($urandom);
                bus.pslverr = 1'($urandom);
                bus.prdata  = $urandom;
            end
            if (bus.hready_resp) begin
                done = 1;
            end else begin
                last_hresp = bus.hresp;
                last_hrdy  = bus.hready_resp;
            end
        end
        chk("latency", c, lat);
        chk("hresp_done", {63'd0, bus.hresp}, {63'd0, eerr});
        chk("hrdata", bus.hrdata, exp_hrdata);
        chk("psel_cycles", pcount, epsel);
        chk("penable_cycles", ecount, epen);
        chk("apb_stable", {63'd0, stab_bad}, 64'd0);
        if (eerr) chk("err1_cycle", {62'd0, last_hresp, last_hrdy}, 64'd2);
    endtask

    task automatic gap(input int n);
        bus.htrans = 2'b00;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        bit wr, er;
        logic [2:0] sz;
        int w, cyc;
        bus.hsel = 0; bus.haddr = '0; bus.hwrite = 0; bus.htrans = 2'b00;
        bus.hsize = 3'd2; bus.hready = 1; bus.hwdata = '0;
        bus.prdata = '0; bus.pready = 0; bus.pslverr = 0;

        // Reset values while rst is high
        #1;
        chk("rst_psel", {63'd0, bus.psel}, 64'd0);
        chk("rst_penable", {63'd0, bus.penable}, 64'd0);
        chk("rst_hready_resp", {63'd0, bus.hready_resp}, 64'd1);
        chk("rst_hresp", {63'd0, bus.hresp}, 64'd0);
        chk("rst_paddr", bus.paddr, 64'd0);
        chk("rst_pwdata", bus.pwdata, 64'd0);
        chk("rst_pwrite", {63'd0, bus.pwrite}, 64'd0);
        chk("rst_hrdata", bus.hrdata, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Zero-wait read, write with 3 waits, read error, byte write
        xfer(1'b0, 3'd2, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
        gap(1);
        xfer(1'b1, 3'd2, 32'h0000_2008, 32'h1234_5678, 32'h0, 3, 1'b0);
        gap(1);
        xfer(1'b0, 3'd2, 32'h0000_300C, 32'h0, 32'hCAFE_F00D, 1, 1'b1);
        gap(1);
        xfer(1'b1, 3'd0, 32'h0000_4001, 32'hAA, 32'h0, 0, 1'b0);
        // Back-to-back read then write
        xfer(1'b0, 3'd1, 32'hABCD_5554, 32'h0, 32'h0BAD_F00D, 0, 1'b0);
        xfer(1'b1, 3'd2, 32'h0000_6000, 32'h5A5A_A5A5, 32'h0, 0, 1'b0);

        // Randomized traffic with 0..2 idle cycles between transfers
        for (int k = 0; k < 40; k++) begin
            wr = 1'($urandom);
            sz = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'd2;
            w  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : 0;
            er = ($urandom_range(0, 3) == 0);
            xfer(wr, sz, $urandom, $urandom, $urandom, w, er);
            gap(int'($urandom_range(0, 2)));
        end

        // Non-transfers must be ignored
        gap(1);
        for (int k = 0; k < 4; k++) begin
            bus.hsel   = (k != 2);
            bus.htrans = (k == 0) ? 2'b00 : (k == 1) ? 2'b01 : 2'b10;
            bus.hready = (k != 3);
            bus.hwrite = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk("ignored_psel", {63'd0, bus.psel}, 64'd0);
            chk("ignored_ready", {63'd0, bus.hready_resp}, 64'd1);
        end
        bus.hready = 1'b1;
        bus.htrans = 2'b00;
        @(negedge clk);

        // Reset pulse in the middle of ACCESS
        bus.hsel = 1; bus.htrans = 2'b10; bus.haddr = 32'h0000_7770;
        bus.hwrite = 0; bus.hsize = 3'd2; bus.pready = 0;
        cyc = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            bus.htrans = 2'b00;
            bus.pready = 0;
            cyc++;
        end while (!bus.penable && cyc < 20);
        chk("reach_access", {63'd0, bus.penable}, 64'd1);
        rst = 1'b1;
        #1;
        chk("midrst_psel", {63'd0, bus.psel}, 64'd0);
        chk("midrst_penable", {63'd0, bus.penable}, 64'd0);
        chk("midrst_hready_resp", {63'd0, bus.hready_resp}, 64'd1);
        chk("midrst_paddr", bus.paddr, 64'd0);
        chk("midrst_hrdata", bus.hrdata, 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_hrdata = '0;
        @(posedge clk);
        #1;
        chk("postrst_psel", {63'd0, bus.psel}, 64'd0);
        chk("postrst_ready", {63'd0, bus.hready_resp}, 64'd1);
        @(negedge clk);
        xfer(1'b0, 3'd2, 32'h0000_1234, 32'h0, 32'h7777_1111, 0, 1'b0);
        gap(1);

        // Completer stalls for 300 ACCESS cycles
        xfer(1'b0, 3'd2, 32'h0000_8888, 32'h0, 32'h1357_9BDF, 300, 1'b0);
        gap(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
